// File: rtl/cdb_arbiter_pkg.sv
// Shared system definitions and CDB completion-request types.
// Provides the `N_WAY / `CDB_BITS machine-width macros once, mirrors them as
// package localparams, and defines the FU completion request payload so that
// functional units and the arbiter agree on one layout.
`ifndef CDB_SYS_DEFS_SVH
`define CDB_SYS_DEFS_SVH
`define N_WAY    2
`define CDB_BITS 6
`endif

package cdb_arbiter_pkg;

    localparam int unsigned N_WAY    = `N_WAY;
    localparam int unsigned CDB_BITS = `CDB_BITS;
    localparam int unsigned NUM_W    = $clog2(N_WAY) + 1;

    typedef logic [CDB_BITS-1:0] cdb_tag_t;

    // One functional unit's completion request (FU_COMPLETE_REQ).
    typedef struct packed {
        logic     valid;
        cdb_tag_t tag;
    } fu_complete_req_t;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational multi-grant round-robin selector.
// Ports:
//   req         - per-requester eligible request
//   ptr         - scan start index
//   grant_c     - per-requester grant (at most N_WAY bits set)
//   slot_idx_c  - requester index placed in each broadcast slot, scan order
//   slot_vld_c  - slot carries a grant
//   next_ptr_c  - one past the last granted index (mod N_FU), else ptr
//   any_grant_c - at least one grant issued
module rr_picker
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned N_FU  = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_FU-1:0]             req,
    input  logic [PTR_W-1:0]            ptr,
    output logic [N_FU-1:0]             grant_c,
    output logic [N_WAY-1:0][PTR_W-1:0] slot_idx_c,
    output logic [N_WAY-1:0]            slot_vld_c,
    output logic [PTR_W-1:0]            next_ptr_c,
    output logic                        any_grant_c
);

    // Walk N_FU positions from ptr with wrap, filling slots in order.
    always_comb begin
        logic [PTR_W:0]   pos;
        logic [PTR_W-1:0] idx;
        logic [NUM_W-1:0] n;
        grant_c     = '0;
        slot_idx_c  = '0;
        slot_vld_c  = '0;
        next_ptr_c  = ptr;
        any_grant_c = 1'b0;
        n           = '0;
        for (int k = 0; k < int'(N_FU); k++) begin
            pos = {1'b0, ptr} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(N_FU)) begin
                pos = pos - (PTR_W+1)'(N_FU);
            end
            idx = pos[PTR_W-1:0];
            if (req[idx] && (n < NUM_W'(N_WAY))) begin
                grant_c[idx] = 1'b1;
                for (int s = 0; s < int'(N_WAY); s++) begin
                    if (n == NUM_W'(s)) begin
                        slot_idx_c[s] = idx;
                        slot_vld_c[s] = 1'b1;
                    end
                end
                next_ptr_c  = (pos == (PTR_W+1)'(N_FU - 1)) ? '0 : PTR_W'(pos + 1'b1);
                any_grant_c = 1'b1;
                n           = n + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: selects up to N_WAY completing functional units per
// cycle in round-robin order and broadcasts their tags one cycle later.
// Ports:
//   clock, reset  - clock and synchronous active-low reset
//   fu_valid/tag  - per-FU completion request (tag 0 is never granted)
//   squash        - flush: no grants, broadcast register cleared
//   fu_ready      - combinational per-FU grant
//   cdb_tag       - registered broadcast tags, 0 marks an empty slot
//   cdb_num       - registered number of filled slots
//   conflict_cnt  - saturating count of cycles with more than N_WAY eligible
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned N_FU  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [N_FU-1:0]                 fu_valid,
    input  logic [N_FU-1:0][CDB_BITS-1:0]   fu_tag,
    input  logic                            squash,
    output logic [N_FU-1:0]                 fu_ready,
    output logic [N_WAY-1:0][CDB_BITS-1:0]  cdb_tag,
    output logic [NUM_W-1:0]                cdb_num,
    output logic [CNT_W-1:0]                conflict_cnt
);

    localparam int unsigned PTR_W  = (N_FU > 1) ? $clog2(N_FU) : 1;
    localparam int unsigned ECNT_W = $clog2(N_FU + 1);

    fu_complete_req_t [N_FU-1:0]     req;
    logic [N_FU-1:0]                 elig;
    logic [ECNT_W-1:0]               elig_cnt;
    logic                            arb_en;
    logic [N_FU-1:0]                 grant;
    logic [N_WAY-1:0][PTR_W-1:0]     slot_idx;
    logic [N_WAY-1:0]                slot_vld;
    logic [PTR_W-1:0]                next_ptr;
    logic                            any_grant;

    logic [N_WAY-1:0][CDB_BITS-1:0]  cdb_tag_d, cdb_tag_q;
    logic [NUM_W-1:0]                cdb_num_d, cdb_num_q;
    logic [PTR_W-1:0]                rr_ptr_d, rr_ptr_q;
    logic [CNT_W-1:0]                conflict_cnt_d, conflict_cnt_q;

    // Eligibility: valid with a non-zero tag.
    always_comb begin
        elig_cnt = '0;
        for (int i = 0; i < int'(N_FU); i++) begin
            req[i]   = '{valid: fu_valid[i], tag: fu_tag[i]};
            elig[i]  = req[i].valid && (req[i].tag != '0);
            elig_cnt = elig_cnt + ECNT_W'(elig[i]);
        end
    end

    // Reset and squash both suppress arbitration entirely.
    assign arb_en = reset && !squash;

    rr_picker #(
        .N_FU  (N_FU),
        .PTR_W (PTR_W)
    ) u_picker (
        .req         (elig & {N_FU{arb_en}}),
        .ptr         (rr_ptr_q),
        .grant_c     (grant),
        .slot_idx_c  (slot_idx),
        .slot_vld_c  (slot_vld),
        .next_ptr_c  (next_ptr),
        .any_grant_c (any_grant)
    );

    assign fu_ready = grant;

    // Next-state: broadcast slots, slot count, pointer, conflict counter.
    always_comb begin
        cdb_tag_d      = '0;
        cdb_num_d      = '0;
        rr_ptr_d       = rr_ptr_q;
        conflict_cnt_d = conflict_cnt_q;
        for (int s = 0; s < int'(N_WAY); s++) begin
            if (slot_vld[s]) begin
                cdb_tag_d[s] = fu_tag[slot_idx[s]];
                cdb_num_d    = cdb_num_d + 1'b1;
            end
        end
        if (any_grant) begin
            rr_ptr_d = next_ptr;
        end
        if (arb_en && (elig_cnt > ECNT_W'(N_WAY)) && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cdb_tag_q      <= '0;
            cdb_num_q      <= '0;
            rr_ptr_q       <= '0;
            conflict_cnt_q <= '0;
        end else begin
            cdb_tag_q      <= cdb_tag_d;
            cdb_num_q      <= cdb_num_d;
            rr_ptr_q       <= rr_ptr_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign cdb_tag      = cdb_tag_q;
    assign cdb_num      = cdb_num_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed cases followed by randomized
// traffic, compared against a scan-list reference model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned NF = 4;
    localparam int unsigned CW = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic                           clock = 1'b0;
    logic                           reset;
    logic [NF-1:0]                  fu_valid;
    logic [NF-1:0][CDB_BITS-1:0]    fu_tag;
    logic                           squash;
    logic [NF-1:0]                  fu_ready;
    logic [N_WAY-1:0][CDB_BITS-1:0] cdb_tag;
    logic [NUM_W-1:0]               cdb_num;
    logic [CW-1:0]                  conflict_cnt;

    always #5 clock = ~clock;

    cdb_arbiter #(.N_FU(NF), .CNT_W(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .fu_valid     (fu_valid),
        .fu_tag       (fu_tag),
        .squash       (squash),
        .fu_ready     (fu_ready),
        .cdb_tag      (cdb_tag),
        .cdb_num      (cdb_num),
        .conflict_cnt (conflict_cnt)
    );

    // Reference model state
    int                             m_ptr;
    logic [N_WAY-1:0][CDB_BITS-1:0] m_tag;
    int                             m_num;
    int                             m_cnt;
    int                             wait_c [NF];
    logic [NF-1:0]                  last_rdy;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational grant, advance model, check registers.
    task automatic step(input logic rst, input logic sq, input logic [NF-1:0] v,
                        input logic [NF-1:0][CDB_BITS-1:0] t);
        int            q[$];
        int            ng;
        logic [NF-1:0] exp_rdy;
        reset    = rst;
        squash   = sq;
        fu_valid = v;
        fu_tag   = t;
        #2;
        for (int k = 0; k < int'(NF); k++) begin
            int i;
            i = (m_ptr + k) % NF;
            if (v[i] && t[i] != '0) q.push_back(i);
        end
        ng = (rst && !sq) ? ((q.size() > N_WAY) ? N_WAY : q.size()) : 0;
        exp_rdy = '0;
        for (int s = 0; s < ng; s++) exp_rdy[q[s]] = 1'b1;
        last_rdy = fu_ready;
        chk("fu_ready", 32'(fu_ready), 32'(exp_rdy));
        // starvation bound: at most ceil(NF/N_WAY)-1 lost rounds in a row
        if (!rst) begin
            for (int i = 0; i < int'(NF); i++) wait_c[i] = 0;
        end else if (!sq) begin
            for (int i = 0; i < int'(NF); i++) begin
                if (!(v[i] && t[i] != '0) || exp_rdy[i]) wait_c[i] = 0;
                else begin
                    wait_c[i]++;
                    chk("starve_bound", 32'(wait_c[i] < 2), 32'd1);
                end
            end
        end
        @(posedge clock);
        #1;
        if (!rst) begin
            m_tag = '0; m_num = 0; m_ptr = 0; m_cnt = 0;
        end else if (sq) begin
            m_tag = '0; m_num = 0;
        end else begin
            m_tag = '0;
            for (int s = 0; s < ng; s++) m_tag[s] = t[q[s]];
            m_num = ng;
            if (ng > 0) m_ptr = (q[ng-1] + 1) % NF;
            if (q.size() > N_WAY && m_cnt < MAXC) m_cnt++;
        end
        chk("cdb_tag", 32'(cdb_tag), 32'(m_tag));
        chk("cdb_num", 32'(cdb_num), 32'(m_num));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    endtask

    initial begin
        logic [NF-1:0]               pv;
        logic [NF-1:0][CDB_BITS-1:0] pt;
        m_ptr = 0; m_tag = '0; m_num = 0; m_cnt = 0;
        for (int i = 0; i < int'(NF); i++) wait_c[i] = 0;
        reset = 1'b0; squash = 1'b0; fu_valid = '0; fu_tag = '0;
        @(posedge clock);
        #1;

        // reset with all requesters valid
        step(1'b0, 1'b0, 4'b1111, {6'd8, 6'd7, 6'd6, 6'd5});
        step(1'b0, 1'b0, 4'b1111, {6'd8, 6'd7, 6'd6, 6'd5});
        chk("rst_ready", 32'(last_rdy), 32'h0);
        chk("rst_tag", 32'(cdb_tag), 32'h0);

        // four requesters from pointer 0, then the remaining two
        step(1'b1, 1'b0, 4'b1111, {6'd8, 6'd7, 6'd6, 6'd5});
        chk("rr_first_ready", 32'(last_rdy), 32'b0011);
        chk("rr_first_tag", 32'(cdb_tag), 32'({6'd6, 6'd5}));
        step(1'b1, 1'b0, 4'b1100, {6'd8, 6'd7, 6'd6, 6'd5});
        chk("rr_second_tag", 32'(cdb_tag), 32'({6'd8, 6'd7}));

        // move pointer to 3, then wrap-around fill
        step(1'b1, 1'b0, 4'b0100, {6'd0, 6'd7, 6'd0, 6'd0});
        step(1'b1, 1'b0, 4'b1001, {6'd10, 6'd0, 6'd0, 6'd9});
        chk("wrap_tag", 32'(cdb_tag), 32'({6'd9, 6'd10}));

        // squash leaves pointer alone (next grant starts at 1)
        step(1'b1, 1'b1, 4'b1111, {6'd1, 6'd2, 6'd3, 6'd4});
        chk("squash_ready", 32'(last_rdy), 32'h0);
        step(1'b1, 1'b0, 4'b1111, {6'd1, 6'd2, 6'd3, 6'd4});
        chk("post_squash_ready", 32'(last_rdy), 32'b0110);

        // tag-0 request ignored, pointer held at 3
        step(1'b1, 1'b0, 4'b0010, {6'd0, 6'd0, 6'd0, 6'd0});
        chk("tag0_num", 32'(cdb_num), 32'h0);
        step(1'b1, 1'b0, 4'b1111, {6'd11, 6'd12, 6'd13, 6'd14});
        chk("tag0_ptr_ready", 32'(last_rdy), 32'b1001);

        // saturate the conflict counter with three eligible
        for (int n = 0; n < 20; n++) step(1'b1, 1'b0, 4'b0111, {6'd0, 6'd3, 6'd2, 6'd1});
        chk("conflict_sat", 32'(conflict_cnt), 32'(MAXC));

        // reset mid-operation restarts from pointer 0
        step(1'b0, 1'b0, 4'b1111, {6'd21, 6'd22, 6'd23, 6'd24});
        step(1'b1, 1'b0, 4'b1111, {6'd21, 6'd22, 6'd23, 6'd24});
        chk("post_rst_ready", 32'(last_rdy), 32'b0011);

        // randomized traffic: requesters hold until granted
        pv = '0; pt = '0;
        for (int n = 0; n < 400; n++) begin
            logic r, s;
            for (int i = 0; i < int'(NF); i++) begin
                if (!pv[i] || pt[i] == '0) begin
                    pv[i] = 1'($urandom_range(0, 1));
                    pt[i] = ($urandom_range(0, 7) == 0) ? '0 : CDB_BITS'($urandom_range(1, 63));
                end
            end
            r = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            s = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
            step(r, s, pv, pt);
            pv = pv & ~last_rdy;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_FU, default 4, meaning number of functional-unit completion requesters (N_FU >= `N_WAY).
REQ-002 Parameter CNT_W, default 16, meaning width of the conflict performance counter.
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset; sampled only at the rising clock edge.
REQ-005 Port fu_valid  input  N_FU  requester i holds a completed destination tag.
REQ-006 Port fu_tag  input  N_FU x `CDB_BITS  destination physical-register tag of requester i.
REQ-007 Port squash  input  1  flush: discard this cycle's arbitration and clear the broadcast register.
REQ-008 Port fu_ready  output  N_FU  requester i granted this cycle; combinational.
REQ-009 Port cdb_tag  output  `N_WAY x `CDB_BITS  registered broadcast tags to complete_dest_tag; 0 = empty slot.
REQ-010 Port cdb_num  output  $clog2(`N_WAY)+1  registered count of non-zero slots in cdb_tag.
REQ-011 Port conflict_cnt  output  CNT_W  saturating count of cycles with more eligible requests than `N_WAY.

Function
REQ-012 Eligible request: fu_valid[i]=1 and fu_tag[i]!=0; tag 0 requests are ignored and never granted.
REQ-013 Transfer occurs when fu_valid[i] && fu_ready[i]; requester shall hold valid and tag stable until then.
REQ-014 Each cycle, scan starting at rr_ptr, ascending index modulo N_FU; grant the first up to `N_WAY eligible requesters.
REQ-015 Granted tags fill cdb_tag slots in scan order, slot 0 first; unfilled slots load 0 at next edge.
REQ-016 Latency: tag granted in cycle t appears on cdb_tag in cycle t+1, exactly one cycle, not repeated.
REQ-017 cdb_num at t+1 equals number of grants in cycle t.
REQ-018 rr_ptr next = (index of last granted requester + 1) mod N_FU; unchanged when no grant.
REQ-019 Wrap-around: scan passing N_FU-1 continues at 0; no requester granted twice in one cycle.
REQ-020 Non-granted eligible requesters keep fu_ready=0 and retry; round-robin guarantees grant within ceil(N_FU/`N_WAY) cycles.
REQ-021 squash=1: fu_ready all 0, cdb_tag and cdb_num load 0, rr_ptr unchanged, conflict_cnt unchanged.
REQ-022 conflict_cnt increments by 1 when eligible count > `N_WAY and squash=0; holds at 2^CNT_W-1.
REQ-023 No request eligible: fu_ready all 0, cdb_tag loads all 0, cdb_num loads 0.

Reset
REQ-024 reset=0 at an edge: cdb_tag=0, cdb_num=0, rr_ptr=0, conflict_cnt=0.
REQ-025 While reset=0, fu_ready all 0; squash and requests ignored.
REQ-026 Reset mid-operation: pending requests are not granted; after reset deasserts they arbitrate from rr_ptr=0.

Structure
REQ-027 `N_WAY and `CDB_BITS come from the shared sys_defs header; no local redefinition.
REQ-028 FU_COMPLETE_REQ typedef (valid, tag) belongs in the shared package for reuse by functional units.
REQ-029 One sub-module rr_picker: combinational multi-grant round-robin selector (requests, pointer -> grant vector, slot order).
REQ-030 State limited to cdb_tag, cdb_num, rr_ptr, conflict_cnt registers.

Verification (N_FU=4, `N_WAY=2)
REQ-031 reset=0 with all fu_valid=1 -> fu_ready=0000, cdb_tag={0,0}, cdb_num=0 after edge.
REQ-032 rr_ptr=0, valid 1111, tags 5,6,7,8 -> fu_ready=0011; next cycle cdb_tag={5,6}, cdb_num=2, rr_ptr=2; then {7,8}, rr_ptr=0.
REQ-033 rr_ptr=3, valid 1001, tags FU0=9, FU3=10 -> slot0=10, slot1=9, rr_ptr=1.
REQ-034 squash=1 with valid 1111 -> fu_ready=0000, cdb_tag {0,0} next cycle, rr_ptr unchanged.
REQ-035 Three eligible for one cycle -> conflict_cnt +1; preload 0xFFFF then conflict -> stays 0xFFFF.
REQ-036 Only FU1 valid with tag 0 -> fu_ready=0000, cdb_num=0, rr_ptr unchanged.
